lpf_channel_scheduler: RTL

//  Time-multiplexes one first-order RC low-pass datapath across NUM_CH independent input streams.
//  - Holds one filter state per channel.
//  - Arbitrates round-robin among valid channels.
//  - Runs one sample through the shared multiply-add.
//  - Emits the result as a single channel-tagged output stream.

---
 rtl/lpf_channel_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/lpf_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lpf_channel_scheduler
// Desc     : Round-robin time-multiplexed first-order RC low-pass over NUM_CH
//            channels; optional per-channel alpha via LPF_SCHED_CH_ALPHA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lpf_channel_scheduler #(
    parameter  int NUM_CH = 4,
    parameter  int W      = 16,
    parameter  int W_FRAC = 8,
    parameter  int ALPHA  = 16'h40,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef LPF_SCHED_CH_ALPHA_EN
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [W-1:0]        cfg_alpha,
`endif
    input  logic [NUM_CH*W-1:0] x_data,
    input  logic [NUM_CH-1:0]   x_valid,
    output logic [NUM_CH-1:0]   x_ready,
    output logic [W-1:0]        y_data,
    output logic [CH_W-1:0]     y_ch,
    output logic                y_valid,
    input  logic                y_ready,
    input  logic                clear,
    output logic                busy
);

    localparam int ONE = 1 << W_FRAC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } fsm_t;

    fsm_t                  r_fsm;
    fsm_t                  w_fsm_nxt;
    logic signed [W-1:0]   r_st [NUM_CH];
    logic signed [W-1:0]   w_x  [NUM_CH];
    logic signed [W-1:0]   r_x;
    logic [CH_W-1:0]       r_g;
    logic [CH_W-1:0]       r_last;
    logic [CH_W-1:0]       w_gnt;
    logic                  w_found;
    logic [W-1:0]          w_alpha;
    logic signed [W+1:0]   w_ca;
    logic signed [W+1:0]   w_cs;
    logic signed [2*W+1:0] w_acc;
    logic [W-1:0]          w_y;
    logic                  w_unused_acc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_x[gi] = x_data[gi*W +: W];
        end
    endgenerate

    function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] base, input int k);
        int t;
        t = int'(base) + k;
        if (t >= NUM_CH) t = t - NUM_CH;
        return CH_W'(t);
    endfunction

    // Scan starts one past the last served channel so every channel gets its turn.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && x_valid[wrap_inc(r_last, k)]) begin
                w_found = 1'b1;
                w_gnt   = wrap_inc(r_last, k);
            end
        end
    end

    always_comb begin
        x_ready = '0;
        if (r_fsm == S_IDLE && w_found) x_ready[w_gnt] = 1'b1;
    end

    assign busy = (r_fsm != S_IDLE);

`ifdef LPF_SCHED_CH_ALPHA_EN
    logic [W-1:0] r_alpha [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_alpha[i] <= W'(ALPHA);
        end else if (cfg_we) begin
            r_alpha[cfg_ch] <= (cfg_alpha > W'(ONE)) ? W'(ONE) : cfg_alpha;
        end
    end

    assign w_alpha = r_alpha[r_g];
`else
    assign w_alpha = W'(ALPHA);
`endif

    // Both coefficients are non-negative and sum to ONE, so the sum cannot overflow.
    always_comb begin
        w_ca  = $signed({2'b00, w_alpha});
        w_cs  = $signed((W+2)'(ONE)) - w_ca;
        w_acc = (2*W+2)'(w_cs) * (2*W+2)'(r_st[r_g])
              + (2*W+2)'(w_ca) * (2*W+2)'(r_x);
        w_y   = w_acc[W_FRAC +: W];
    end

    assign w_unused_acc = ^{w_acc[2*W+1:W_FRAC+W], w_acc[W_FRAC-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        if (clear) begin
            w_fsm_nxt = S_IDLE;
        end else begin
            case (r_fsm)
                S_IDLE:  if (w_found) w_fsm_nxt = S_CALC;
                S_CALC:  w_fsm_nxt = S_OUT;
                S_OUT:   if (y_ready) w_fsm_nxt = S_IDLE;
                default: w_fsm_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_st[i] <= '0;
            r_x     <= '0;
            r_g     <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
            y_data  <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) r_st[i] <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
            y_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (w_found) begin
                        r_x <= w_x[w_gnt];
                        r_g <= w_gnt;
                    end
                end
                S_CALC: begin
                    r_st[r_g] <= w_y;
                    y_data    <= w_y;
                    y_ch      <= r_g;
                    y_valid   <= 1'b1;
                end
                S_OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        r_last  <= r_g;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
